iter_operand_shifter: RTL

- Multi-cycle operand shifter directly upstream of the ALU. Produces the ALU's second operand (b) and the shifter carry, which feeds the ALU carry input (cin) for logical ops.
- Implements the four data-processing shift types (LSL, LSR, ASR, ROR), plus RRX and the rotated 8-bit immediate.
- Shifts one bit per clock under a start/done handshake, trading latency for area.
- The control unit holds the ALU stage until done.

---
 rtl/iter_operand_shifter.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/iter_operand_shifter.sv
// Bit-serial operand shifter feeding the ALU b operand and the logical-op carry.
// One shift step per clock; a start/done handshake brackets each operation.
module iter_operand_shifter #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] op_in,
   input  logic [7:0]       shamt,
   input  logic [1:0]       stype,
   input  logic [1:0]       mode,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] shifter_out,
   output logic             shifter_cout
);

   localparam int CW = $clog2(WIDTH + 2);
   localparam int AW = $clog2(WIDTH);

   typedef enum logic {
      IDLE,
      SHIFT
   } state_t;

   typedef enum logic [2:0] {
      K_LSL,
      K_LSR,
      K_ASR,
      K_ROR,
      K_RRX
   } kind_t;

   state_t           state_q, state_d;
   kind_t            kind_q, kind_d;
   logic [WIDTH-1:0] r_q, r_d;
   logic             c_q, c_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             done_q, done_d;
   logic [WIDTH-1:0] out_q, out_d;
   logic             cout_q, cout_d;

   kind_t            loadKind;
   logic [WIDTH-1:0] loadR;
   logic             loadC;
   logic [CW-1:0]    loadN;
   kind_t            typeKind;
   logic [AW-1:0]    amtLow;
   logic [WIDTH-1:0] stepR;
   logic             stepC;

   assign amtLow = shamt[AW-1:0];

   always_comb begin
      typeKind = K_LSL;
      unique case (stype)
         2'b00:   typeKind = K_LSL;
         2'b01:   typeKind = K_LSR;
         2'b10:   typeKind = K_ASR;
         default: typeKind = K_ROR;
      endcase
   end

   // Decode the request into a working value, starting carry, step count and step kind.
   // A zero count means the working value/carry are already the final answer.
   always_comb begin
      loadKind = typeKind;
      loadR    = op_in;
      loadC    = cin;
      loadN    = '0;
      unique case (mode)
         2'b00: begin
            if (amtLow != '0) begin
               loadN = CW'(amtLow);
            end else begin
               unique case (stype)
                  2'b00:   loadN = '0;
                  2'b01:   loadN = CW'(WIDTH);
                  2'b10:   loadN = CW'(WIDTH);
                  default: begin
                     loadKind = K_RRX;
                     loadN    = CW'(1);
                  end
               endcase
            end
         end
         2'b01: begin
            if (shamt != 8'd0) begin
               unique case (stype)
                  2'b00, 2'b01: begin
                     loadN = (shamt > 8'(WIDTH + 1)) ? CW'(WIDTH + 1) : CW'(shamt);
                  end
                  2'b10: begin
                     loadN = (shamt > 8'(WIDTH)) ? CW'(WIDTH) : CW'(shamt);
                  end
                  default: begin
                     if (amtLow != '0) begin
                        loadN = CW'(amtLow);
                     end else begin
                        loadC = op_in[WIDTH-1];
                     end
                  end
               endcase
            end
         end
         2'b10: begin
            loadKind = K_ROR;
            loadR    = {{(WIDTH-8){1'b0}}, op_in[7:0]};
            loadN    = CW'({shamt[3:0], 1'b0});
         end
         default: begin
            loadN = '0;
         end
      endcase
   end

   always_comb begin
      stepR = r_q;
      stepC = c_q;
      unique case (kind_q)
         K_LSL: begin
            stepC = r_q[WIDTH-1];
            stepR = {r_q[WIDTH-2:0], 1'b0};
         end
         K_LSR: begin
            stepC = r_q[0];
            stepR = {1'b0, r_q[WIDTH-1:1]};
         end
         K_ASR: begin
            stepC = r_q[0];
            stepR = {r_q[WIDTH-1], r_q[WIDTH-1:1]};
         end
         K_ROR: begin
            stepC = r_q[0];
            stepR = {r_q[0], r_q[WIDTH-1:1]};
         end
         K_RRX: begin
            stepC = r_q[0];
            stepR = {c_q, r_q[WIDTH-1:1]};
         end
         default: begin
            stepR = r_q;
            stepC = c_q;
         end
      endcase
   end

   // Outputs are copied only when the count is exhausted, so they stay stable
   // through the next operation until its own done.
   always_comb begin
      state_d = state_q;
      kind_d  = kind_q;
      r_d     = r_q;
      c_d     = c_q;
      cnt_d   = cnt_q;
      done_d  = 1'b0;
      out_d   = out_q;
      cout_d  = cout_q;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               state_d = SHIFT;
               kind_d  = loadKind;
               r_d     = loadR;
               c_d     = loadC;
               cnt_d   = loadN;
            end
         end
         SHIFT: begin
            if (cnt_q == '0) begin
               state_d = IDLE;
               done_d  = 1'b1;
               out_d   = r_q;
               cout_d  = c_q;
            end else begin
               r_d   = stepR;
               c_d   = stepC;
               cnt_d = cnt_q - CW'(1);
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         kind_q  <= K_LSL;
         r_q     <= '0;
         c_q     <= 1'b0;
         cnt_q   <= '0;
         done_q  <= 1'b0;
         out_q   <= '0;
         cout_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         kind_q  <= kind_d;
         r_q     <= r_d;
         c_q     <= c_d;
         cnt_q   <= cnt_d;
         done_q  <= done_d;
         out_q   <= out_d;
         cout_q  <= cout_d;
      end
   end

   assign busy         = (state_q == SHIFT);
   assign done         = done_q;
   assign shifter_out  = out_q;
   assign shifter_cout = cout_q;

endmodule
